// File: rtl/unique_pkg.sv
// Shared types and default sizing for the unique_expand block.
package unique_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 128;
    localparam int unsigned DEF_CW    = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] value;
        logic [DEF_CW-1:0]    count;
    } pair_t;

endpackage

// File: rtl/unique_expand_if.sv
// Load-side and emit-side handshake bundle for unique_expand.
interface unique_expand_if
    import unique_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CW    = DEF_CW
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic [CW-1:0]    in_count;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_value, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_value, in_count, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/unique_pair_buf.sv
// DEPTH-entry (value,count) pair store: one write port, one combinational read port.
module unique_pair_buf
    import unique_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH+CW-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH+CW-1:0]        rdata
);

    logic [WIDTH+CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/unique_expand.sv
// Loads (value,count) pairs, then emits each value count times in load order.
// Optional UNIQUE_EXPAND_ORDER_CHECK_EN adds a sticky order_err output.
module unique_expand
    import unique_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic                        clk,
    input  logic                        rst,
    unique_expand_if.slave              bus,
    output logic                        done,
`ifdef UNIQUE_EXPAND_ORDER_CHECK_EN
    output logic                        order_err,
`endif
    output logic [CW+$clog2(DEPTH):0]   total
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = CW + AW + 1;

    state_t state, state_next;

    logic [PW-1:0]       wr_ptr, wr_base;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       rem;
    logic                fresh;
    logic [TW-1:0]       total_base, total_next;
    logic [WIDTH+CW-1:0] rd_word;
    logic [WIDTH-1:0]    cur_value;
    logic [CW-1:0]       cur_count, cur_rem;
    logic                in_xfer, out_xfer, store, load_end, last_pair, final_elem;

    // A load restarts from zero when it begins in S_IDLE, so total stays readable until then.
    assign wr_base    = (state == S_IDLE) ? '0 : wr_ptr;
    assign total_base = (state == S_IDLE) ? '0 : total;
    assign in_xfer    = bus.in_valid && bus.in_ready;
    assign out_xfer   = bus.out_valid && bus.out_ready;
    assign store      = in_xfer && (bus.in_count != '0);
    assign load_end   = in_xfer && (bus.in_last || (store && (wr_base == PW'(DEPTH - 1))));
    assign total_next = total_base + (store ? TW'(bus.in_count) : '0);

    unique_pair_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk   (clk),
        .we    (store),
        .waddr (wr_base[AW-1:0]),
        .wdata ({bus.in_value, bus.in_count}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // fresh marks a pair whose count has not been latched into rem yet.
    assign cur_value  = rd_word[WIDTH+CW-1:CW];
    assign cur_count  = rd_word[CW-1:0];
    assign cur_rem    = fresh ? cur_count : rem;
    assign last_pair  = ({1'b0, rd_ptr} == (wr_ptr - PW'(1)));
    assign final_elem = last_pair && (cur_rem == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (in_xfer) begin
                    if (load_end) begin
                        state_next = (total_next != '0) ? S_EMIT : S_DONE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_EMIT: begin
                if (out_xfer && final_elem) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = !rst && ((state == S_IDLE) || (state == S_LOAD));
        bus.out_valid = (state == S_EMIT);
        bus.out_data  = (state == S_EMIT) ? cur_value : '0;
        bus.out_last  = (state == S_EMIT) && final_elem;
        done          = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rem    <= '0;
            fresh  <= 1'b1;
            total  <= '0;
        end else begin
            if (in_xfer) begin
                total  <= total_next;
                wr_ptr <= store ? (wr_base + PW'(1)) : wr_base;
                rd_ptr <= '0;
                fresh  <= 1'b1;
            end
            if (out_xfer) begin
                if (cur_rem == CW'(1)) begin
                    if (!last_pair) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                    fresh <= 1'b1;
                end else begin
                    rem   <= cur_rem - CW'(1);
                    fresh <= 1'b0;
                end
            end
        end
    end

`ifdef UNIQUE_EXPAND_ORDER_CHECK_EN
    logic [WIDTH-1:0] prev_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            order_err  <= 1'b0;
            prev_value <= '0;
        end else if (in_xfer) begin
            order_err <= ((state == S_IDLE) ? 1'b0 : order_err)
                       | (store && (wr_base != '0) && (bus.in_value <= prev_value));
            if (store) begin
                prev_value <= bus.in_value;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unique_expand.sv
// Randomized self-checking bench for unique_expand against a queue-based expansion model.
module tb_unique_expand;
    import unique_pkg::*;

    localparam int unsigned WIDTH = DEF_WIDTH;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = DEF_CW;

    logic clk = 1'b0;
    logic rst;
    logic done;
    logic [CW+$clog2(DEPTH):0] total;
`ifdef UNIQUE_EXPAND_ORDER_CHECK_EN
    logic order_err;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    unique_expand_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    unique_expand #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .done      (done),
`ifdef UNIQUE_EXPAND_ORDER_CHECK_EN
        .order_err (order_err),
`endif
        .total     (total)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic pair_t mk(input logic [WIDTH-1:0] v, input logic [CW-1:0] c);
        pair_t p;
        p.value = v;
        p.count = c;
        return p;
    endfunction

    task automatic send_pairs(input pair_t ps[$], input int unsigned n, input bit mark_last);
        int unsigned guard;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_value = ps[i].value;
            bus.in_count = ps[i].count;
            bus.in_last  = mark_last && (i == ps.size() - 1);
            #1;
            guard = 0;
            while (!bus.in_ready && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (!bus.in_ready) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic run_case(input string name, input pair_t ps[$], input bit mark_last,
                            input int unsigned ready_pct);
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] prev = '0;
        logic [WIDTH-1:0] held_data = '0;
        logic             held_last = 1'b0;
        bit               held = 1'b0;
        bit               exp_err = 1'b0;
        bit               finished = 1'b0;
        int unsigned      stored = 0;
        int unsigned      nsend = 0;
        int unsigned      idx = 0;
        int unsigned      guard = 0;
        longint unsigned  sum = 0;

        for (int unsigned i = 0; i < ps.size(); i++) begin
            nsend++;
            if (ps[i].count != 0) begin
                if (stored != 0 && ps[i].value <= prev) exp_err = 1'b1;
                prev = ps[i].value;
                stored++;
                sum += ps[i].count;
                for (int unsigned k = 0; k < ps[i].count; k++) exp_q.push_back(ps[i].value);
            end
            if ((mark_last && i == ps.size() - 1) || stored == DEPTH) break;
        end

        send_pairs(ps, nsend, mark_last);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check({name, ".in_ready_after_load"}, 64'(bus.in_ready), 64'd0);
        check({name, ".out_valid_start"}, 64'(bus.out_valid), 64'(sum != 0));
        check({name, ".total"}, 64'(total), sum);
`ifdef UNIQUE_EXPAND_ORDER_CHECK_EN
        check({name, ".order_err"}, 64'(order_err), 64'(exp_err));
`endif
        if (sum == 0) begin
            check({name, ".done_empty"}, 64'(done), 64'd1);
        end else begin
            while (!finished && guard < 2000) begin
                bus.out_ready = ($urandom_range(0, 99) < ready_pct);
                check({name, ".out_valid"}, 64'(bus.out_valid), 64'd1);
                if (held) begin
                    check({name, ".stall_data"}, 64'(bus.out_data), 64'(held_data));
                    check({name, ".stall_last"}, 64'(bus.out_last), 64'(held_last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (idx >= exp_q.size()) begin
                        check({name, ".extra_beat"}, 64'(idx), 64'(exp_q.size()));
                        finished = 1'b1;
                    end else begin
                        check({name, ".data"}, 64'(bus.out_data), 64'(exp_q[idx]));
                        check({name, ".last"}, 64'(bus.out_last), 64'(idx == exp_q.size() - 1));
                        if (bus.out_last) finished = 1'b1;
                        idx++;
                    end
                    held = 1'b0;
                end else begin
                    held      = bus.out_valid;
                    held_data = bus.out_data;
                    held_last = bus.out_last;
                end
                @(negedge clk);
                #1;
                guard++;
            end
            bus.out_ready = 1'b0;
            check({name, ".emit_finished"}, 64'(finished), 64'd1);
            check({name, ".beats"}, 64'(idx), 64'(exp_q.size()));
            check({name, ".done"}, 64'(done), 64'd1);
            check({name, ".out_valid_end"}, 64'(bus.out_valid), 64'd0);
            check({name, ".total_end"}, 64'(total), sum);
        end
        @(negedge clk);
        #1;
        check({name, ".done_one_cycle"}, 64'(done), 64'd0);
        check({name, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pair_t q[$];
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_count  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.in_ready", 64'(bus.in_ready), 64'd0);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.out_last", 64'(bus.out_last), 64'd0);
        check("rst.out_data", 64'(bus.out_data), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.total", 64'(total), 64'd0);
`ifdef UNIQUE_EXPAND_ORDER_CHECK_EN
        check("rst.order_err", 64'(order_err), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.release_ready", 64'(bus.in_ready), 64'd1);

        q = {mk(8, 2), mk(1, 1), mk(3, 3)};
        run_case("basic", q, 1'b1, 100);
        run_case("stalls", q, 1'b1, 40);

        q = {mk(5, 0), mk(7, 0)};
        run_case("zero", q, 1'b1, 100);

        q = {mk(1, 1), mk(2, 2), mk(3, 1), mk(4, 1)};
        run_case("full", q, 1'b0, 100);

        q = {mk(10, 1), mk(11, 0), mk(12, 2), mk(13, 1), mk(14, 3), mk(15, 1)};
        run_case("full_trunc", q, 1'b1, 70);

        q = {mk(4, 1), mk(2, 1)};
        run_case("order", q, 1'b1, 100);

        // Reset two beats into a five-beat expansion.
        q = {mk(1, 2), mk(2, 3)};
        send_pairs(q, 2, 1'b1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("midrst.beat0", 64'(bus.out_data), 64'd1);
        @(negedge clk);
        #1;
        check("midrst.beat1", 64'(bus.out_data), 64'd1);
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        check("midrst.in_ready_rst", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        #1;
        check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst.out_data", 64'(bus.out_data), 64'd0);
        check("midrst.out_last", 64'(bus.out_last), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst.in_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("midrst.no_done", 64'(done), 64'd0);
        end
        q = {mk(9, 1)};
        run_case("reload", q, 1'b1, 100);

        for (int unsigned t = 0; t < 30; t++) begin
            int unsigned n;
            int unsigned nz;
            bit          ml;
            bit          sorted;
            logic [WIDTH-1:0] base;
            q.delete();
            n      = $urandom_range(1, 6);
            sorted = $urandom_range(0, 1);
            base   = $urandom_range(0, 1000);
            nz     = 0;
            for (int unsigned i = 0; i < n; i++) begin
                int unsigned r;
                logic [CW-1:0] c;
                logic [WIDTH-1:0] v;
                r = $urandom_range(0, 19);
                if (r < 5)        c = '0;
                else if (r == 19) c = '1;
                else              c = CW'($urandom_range(1, 4));
                v = sorted ? base + WIDTH'(i * 7) : WIDTH'($urandom);
                if (c != 0) nz++;
                q.push_back(mk(v, c));
            end
            ml = (nz < DEPTH) ? 1'b1 : 1'(($urandom_range(0, 1)));
            run_case("random", q, ml, $urandom_range(30, 100));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unique_expand.md
UNIQUE_EXPAND -- requirements
Module: unique_expand

Interface
REQ-001 Parameter WIDTH, default 32, element width in bits.
REQ-002 Parameter DEPTH, default 128, maximum stored (value,count) pairs.
REQ-003 Parameter CW, default 8, multiplicity (count) width in bits.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  load pair valid.
REQ-007 in_ready  output  1  block accepts pair this cycle.
REQ-008 in_value  input  WIDTH  unique element value.
REQ-009 in_count  input  CW  multiplicity of in_value.
REQ-010 in_last  input  1  final pair of the list.
REQ-011 out_valid  output  1  expanded element valid.
REQ-012 out_ready  input  1  downstream accepts element.
REQ-013 out_data  output  WIDTH  expanded element.
REQ-014 out_last  output  1  final expanded element.
REQ-015 done  output  1  one-cycle pulse when expansion completes.
REQ-016 total  output  CW+$clog2(DEPTH)+1  sum of stored counts; valid from S_EMIT entry until next load.

Function
REQ-017 FSM states: S_IDLE, S_LOAD, S_EMIT, S_DONE.
REQ-018 Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-019 in_ready = 1 in S_IDLE and S_LOAD, 0 in S_EMIT and S_DONE.
REQ-020 S_IDLE: the first input transfer stores the pair and moves to S_LOAD, or to S_EMIT/S_DONE when in_last is set.
REQ-021 Pairs with in_count == 0 are not stored or counted; their in_last still ends the load.
REQ-022 Load ends on an in_last transfer or on the transfer of the DEPTH-th stored pair; a pair beyond that is impossible because in_ready is 0.
REQ-023 At load end: total != 0 -> S_EMIT; total == 0 -> S_DONE; no output beats occur.
REQ-024 S_EMIT: out_valid = 1 continuously; out_data = the value of the current pair, emitted count times in load order; one element per output transfer, no bubbles.
REQ-025 First out_valid appears the cycle after the load-ending transfer.
REQ-026 out_data and out_last hold stable while out_valid && !out_ready.
REQ-027 out_last = 1 exactly on the final element (the last stored pair with its remaining count == 1).
REQ-028 The out_last transfer -> S_DONE; S_DONE asserts done for one cycle, then moves to S_IDLE.
REQ-029 Counters are wide enough for DEPTH*(2^CW-1); no wrap-around is permitted.

Reset
REQ-030 rst is sampled at clk: state=S_IDLE, pair/element pointers=0, total=0, in_ready=0 in the reset cycle, out_valid=0, out_last=0, done=0, out_data=0.
REQ-031 rst mid-load or mid-emit discards all stored pairs; there is no done pulse; in_ready=1 the cycle after rst deasserts.
REQ-032 Buffer contents are not cleared; reads are only from entries written in the current load.

Configuration
REQ-033 Macro UNIQUE_EXPAND_ORDER_CHECK_EN defined: adds output order_err (1 bit, reset 0).
REQ-034 order_err sets sticky when a stored in_value is <= the previous stored value (unsigned).
REQ-035 order_err clears on the next S_IDLE-to-S_LOAD entry or on rst.
REQ-036 Macro UNIQUE_EXPAND_ORDER_CHECK_EN undefined: no order_err port and no compare logic; all other behaviour is identical.

Structure
REQ-037 Package unique_pkg holds the state enum, default WIDTH/DEPTH/CW constants, and the pair struct {value, count}.
REQ-038 Sub-module unique_pair_buf: a DEPTH-entry pair RAM with one write port and one read port, written only during load.
REQ-039 The FSM, pointers and the remaining-count down-counter live in the top module.

Verification
REQ-040 Load (8,2),(1,1),(3,3) last -> out 8,8,1,3,3,3; out_last on the 6th element; total=6; done one cycle after.
REQ-041 Random out_ready stalls on REQ-040 -> same sequence; out_data stable across every stall.
REQ-042 Load (5,0),(7,0) last -> no out_valid; S_DONE entered directly; done pulses; total=0.
REQ-043 DEPTH=4, stream 4 pairs with no in_last -> in_ready drops after the 4th; emission starts the next cycle.
REQ-044 rst asserted after 2 of 5 expected output transfers -> out_valid=0, done never pulses; a new load of (9,1) last outputs the single element 9 with out_last.
REQ-045 With UNIQUE_EXPAND_ORDER_CHECK_EN defined, load (4,1),(2,1) last -> order_err=1 and expansion still outputs 4,2.
